osecpu_debug_capture: RTL
=========================

Name: osecpu_debug_capture

Overview:
- Parametrised successor to the core's single CPDR debug register.
- Captures 32-bit register values written by debug-output instructions into CHANNELS independent "latest value" registers.
- Also queues every capture, tagged with its channel, in a DEPTH-entry FIFO so a host/UART drainer can read the full trace.
- Sits beside the controller/datapath; driven from the STATE_EXEC cycle of the CPDR-family opcode.

Parameters:
- DATA_W, 32: width of captured value.
- CHANNELS, 4: number of latest-value registers (1..256).
- DEPTH, 8: FIFO entries (power of two, >=2).
- CNT_W, 16: width of saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cap_valid  in  1  capture strobe; one capture per asserted cycle.
- cap_ch  in  8  channel index (instr operand byte).
- cap_data  in  DATA_W  value to capture (ireg_d0).
- dr  out  CHANNELS*DATA_W  latest value per channel; channel k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_ch  out  8  head channel tag.
- out_data  out  DATA_W  head value.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a capture was dropped.
- bad_ch  out  1  sticky: capture with cap_ch >= CHANNELS.
- drop_cnt  out  CNT_W  saturating count of dropped captures.
- clr_flags  in  1  synchronous clear of overflow, bad_ch, drop_cnt.

Behaviour:
- Reset (reset=0, async): all dr channels 0; FIFO empty; out_valid=0; out_ch=0; out_data=0; level=0; overflow=0; bad_ch=0; drop_cnt=0.
- Capture with cap_valid=1 and cap_ch<CHANNELS:
  - dr[cap_ch] <= cap_data at the same edge; visible the next cycle (1-cycle latency).
  - Other channels are unchanged.
- Capture with cap_ch>=CHANNELS: no dr update, no FIFO push, bad_ch<=1.
- FIFO push: every valid-channel capture is pushed as {ch,data}.
- FIFO read side:
  - First-word fall-through: out_valid=1 whenever level>0, and out_ch/out_data show the head combinationally from storage.
  - Pop on out_valid&&out_ready. out_ready while empty has no effect.
  - When empty, out_ch and out_data hold their last value; they are 0 after reset.
- Full (level==DEPTH) with push and no pop: entry dropped, overflow<=1, drop_cnt+1 saturating at all-ones. dr is still updated.
- Full with simultaneous push and pop: both occur, level stays DEPTH, no drop.
- Empty with push: out_valid rises the next cycle. There is no same-cycle bypass.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. level is tracked in a separate counter.
- clr_flags: clears overflow, bad_ch and drop_cnt. If a drop or bad channel occurs in the same cycle, the set wins.
- An async reset mid-burst discards all FIFO contents and in-flight captures.

Optional Feature:
- Macro: OSECPU_DBG_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter, reset to 0 and wrapping, is stored with each FIFO entry.
  - Extra output port out_ts (32 bits) gives the head timestamp, which equals the counter value at the capture edge.
  - out_ts is 0 after reset.
- When undefined: no counter, no out_ts port, FIFO width = 8+DATA_W.

Decomposition:
- Shared package/include (def.v style) holds:
  - DBG_CH_W=8.
  - Default DATA_W/DEPTH.
  - The FIFO entry field offsets (ch, data, ts).
  - The CPDR opcode constant 8'hD3, used by the top to form cap_valid = (op==CPDR)&&(state==STATE_EXEC).
- One sub-module: osecpu_dbg_fifo, a generic sync FWFT FIFO with width/depth parameters, full/empty/level outputs.
- The top block owns the channel registers, decode, flags and timestamp.

Test Plan:
- Reset, then capture ch=2 data=32'hDEADBEEF → next cycle: dr ch2=DEADBEEF, ch0/1/3=0, out_valid=1, out_ch=2, out_data=DEADBEEF, level=1.
- 9 captures (ch0, data 1..9) with out_ready=0, DEPTH=8 → level=8, overflow=1, drop_cnt=1, dr ch0=9; drain yields 1..8 in order.
- Full FIFO, push data=0xAA and pop in the same cycle → level stays 8, overflow unchanged, last drained entry 0xAA.
- Capture ch=7 with CHANNELS=4 → bad_ch=1, level unchanged, dr unchanged; then clr_flags → bad_ch=0.
- Assert reset low mid-stream with level=5 → immediately level=0, out_valid=0, all dr=0, flags 0.
- With OSECPU_DBG_TIMESTAMP_EN defined: captures at cycles 10 and 13 after reset release → out_ts reads 10, then 13.

Source files
------------

// File: rtl/osecpu_debug_capture_pkg.sv
// Shared definitions for the debug capture block (def.v successor).
// Optional macro: OSECPU_DBG_TIMESTAMP_EN adds a 32-bit timestamp field to each FIFO entry.
package osecpu_debug_capture_pkg;

  localparam int unsigned DBG_CH_W       = 8;
  localparam int unsigned DBG_DATA_W     = 32;
  localparam int unsigned DBG_DEPTH      = 8;
  localparam int unsigned DBG_CHANNELS   = 4;
  localparam int unsigned DBG_CNT_W      = 16;

`ifdef OSECPU_DBG_TIMESTAMP_EN
  localparam int unsigned DBG_TS_W       = 32;
`else
  localparam int unsigned DBG_TS_W       = 0;
`endif

  // Entry layout: {data, ts, ch}; ch at the bottom so offsets stay DATA_W-independent.
  localparam int unsigned ENT_CH_OFS     = 0;
  localparam int unsigned ENT_TS_OFS     = DBG_CH_W;
  localparam int unsigned ENT_DATA_OFS   = DBG_CH_W + DBG_TS_W;

  localparam logic [7:0]  DBG_OP_CPDR    = 8'hD3;

  typedef enum logic [1:0] {
    STATE_FETCH,
    STATE_DECODE,
    STATE_EXEC,
    STATE_WB
  } cpu_state_e;

  function automatic logic dbg_cap_strobe(input logic [7:0] op, input cpu_state_e st);
    return (op == DBG_OP_CPDR) && (st == STATE_EXEC);
  endfunction

  function automatic int unsigned dbg_ent_w(input int unsigned data_w);
    return DBG_CH_W + DBG_TS_W + data_w;
  endfunction

endpackage

// File: rtl/osecpu_dbg_fifo.sv
// Generic synchronous first-word-fall-through FIFO with level counter.
module osecpu_dbg_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head comes straight from storage; once empty, the last popped word is held.
  assign rdata_o = empty_o ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/osecpu_debug_capture.sv
// Multi-channel debug capture: latest-value registers plus a tagged trace FIFO.
// Optional macro: OSECPU_DBG_TIMESTAMP_EN adds a cycle counter and the out_ts port.
module osecpu_debug_capture
  import osecpu_debug_capture_pkg::*;
#(
  parameter int unsigned DATA_W   = DBG_DATA_W,
  parameter int unsigned CHANNELS = DBG_CHANNELS,
  parameter int unsigned DEPTH    = DBG_DEPTH,
  parameter int unsigned CNT_W    = DBG_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cap_valid,
  input  logic [DBG_CH_W-1:0]          cap_ch,
  input  logic [DATA_W-1:0]            cap_data,
  output logic [CHANNELS*DATA_W-1:0]   dr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DBG_CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic                         bad_ch,
  output logic [CNT_W-1:0]             drop_cnt,
  input  logic                         clr_flags
`ifdef OSECPU_DBG_TIMESTAMP_EN
  ,
  output logic [31:0]                  out_ts
`endif
);

  localparam int unsigned ENT_W = dbg_ent_w(DATA_W);

  logic [CHANNELS*DATA_W-1:0] dr_q;
  logic                       overflow_q, overflow_d;
  logic                       bad_ch_q, bad_ch_d;
  logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;
  logic                       ch_ok, push, bad, drop;
  logic                       fifo_full, fifo_empty;
  logic [ENT_W-1:0]           wr_ent, rd_ent;

  assign ch_ok = ({1'b0, cap_ch} < 9'(CHANNELS));
  assign push  = cap_valid && ch_ok;
  assign bad   = cap_valid && !ch_ok;
  assign drop  = push && fifo_full && !out_ready;

`ifdef OSECPU_DBG_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end

  assign out_ts = rd_ent[ENT_TS_OFS +: 32];
`endif

  always_comb begin
    wr_ent = '0;
    wr_ent[ENT_CH_OFS +: DBG_CH_W] = cap_ch;
`ifdef OSECPU_DBG_TIMESTAMP_EN
    wr_ent[ENT_TS_OFS +: 32] = ts_q;
`endif
    wr_ent[ENT_DATA_OFS +: DATA_W] = cap_data;
  end

  osecpu_dbg_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (wr_ent),
    .pop_i   (out_ready),
    .rdata_o (rd_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid = !fifo_empty;
  assign out_ch    = rd_ent[ENT_CH_OFS +: DBG_CH_W];
  assign out_data  = rd_ent[ENT_DATA_OFS +: DATA_W];

  // Clear first, then apply this cycle's events so a same-cycle set wins.
  always_comb begin
    overflow_d = clr_flags ? 1'b0 : overflow_q;
    bad_ch_d   = clr_flags ? 1'b0 : bad_ch_q;
    drop_cnt_d = clr_flags ? '0   : drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + CNT_W'(1);
    end
    if (bad) bad_ch_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      bad_ch_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      bad_ch_q   <= bad_ch_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dr_q <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (cap_valid && (cap_ch == DBG_CH_W'(k))) dr_q[k*DATA_W +: DATA_W] <= cap_data;
      end
    end
  end

  assign dr       = dr_q;
  assign overflow = overflow_q;
  assign bad_ch   = bad_ch_q;
  assign drop_cnt = drop_cnt_q;

endmodule
